// File: rtl/control_filtro.sv
// Sample-rate sequencer for the biquad high-pass datapath: holds u, waits SETTLE cycles,
// strobes Enable once while capturing y. Optional drop counter: CONTROL_FILTRO_DROPCNT_EN.
module control_filtro #(
  parameter int unsigned W      = 25,
  parameter int unsigned SETTLE = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [W-1:0] u,
  output logic         Enable,
  input  logic [W-1:0] y,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic [7:0]   drop_cnt,
  input  logic         drop_clr
);

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 8;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [DW-1:0] DROP_MAX    = {DW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]  r_u, w_u_nxt;
  logic [W-1:0]  r_out_data, w_out_data_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          w_drop;

  // State and datapath registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_u         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_u         <= w_u_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state and register-load decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_u_nxt         = r_u;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_u_nxt     = in_data;
          w_cnt_nxt   = SETTLE_LOAD;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_CAPTURE: begin
        // y is sampled on the same edge that advances the filter delay line
        w_out_data_nxt  = y;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign Enable    = (r_state == S_CAPTURE);
  assign busy      = (r_state != S_IDLE);
  assign u         = r_u;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign w_drop    = in_valid & ~in_ready;

`ifdef CONTROL_FILTRO_DROPCNT_EN
  logic [DW-1:0] r_drop_cnt;

  // Saturating lost-sample counter; clear has priority over a same-cycle drop
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_drop_cnt <= '0;
    end else if (drop_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + DW'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = ^{drop_clr, w_drop, DROP_MAX};
  assign drop_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_control_filtro.sv
// Bench for control_filtro: a stub filter drives y, and a transaction-timeline model
// predicts every output cycle by cycle; honours CONTROL_FILTRO_DROPCNT_EN.
module tb_control_filtro;

  localparam int unsigned W      = 25;
  localparam int unsigned SETTLE = 4;

  logic         CLK;
  logic         Reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] u;
  logic         Enable;
  logic [W-1:0] y;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic [7:0]   drop_cnt;
  logic         drop_clr;

  control_filtro #(.W(W), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .u(u), .Enable(Enable), .y(y),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Stand-in filter: y = u/2 - x1/2, delay line advances only on Enable
  function automatic logic [W-1:0] yfun(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return W'((a >>> 1) - (b >>> 1));
  endfunction

  logic [W-1:0] x1;
  always @(posedge CLK or posedge Reset) begin
    if (Reset) x1 <= '0;
    else if (Enable) x1 <= u;
  end
  assign y = yfun(u, x1);

  int en_seen = 0;
  always @(posedge CLK) if (Enable) en_seen <= en_seen + 1;

  int total = 0;
  int bad   = 0;

  // Reference model: transaction timeline counted from the accept edge
  logic         m_busy, m_ov;
  int           m_rel;
  int           m_en = 0;
  logic [W-1:0] m_u, m_out, m_x1;
  logic [7:0]   m_drop;

  task automatic model_reset();
    m_busy = 1'b0; m_ov = 1'b0; m_rel = 0;
    m_u = '0; m_out = '0; m_x1 = '0; m_drop = '0;
  endtask

  task automatic model_edge();
    if (drop_clr) m_drop = '0;
    else if (m_busy && in_valid && m_drop != 8'd255) m_drop = m_drop + 8'd1;
    if (!m_busy) begin
      if (in_valid) begin
        m_u = in_data; m_busy = 1'b1; m_rel = 0;
      end
    end else begin
      if (m_rel == int'(SETTLE)) begin
        m_out = yfun(m_u, m_x1); m_x1 = m_u; m_ov = 1'b1; m_en++;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0; m_busy = 1'b0;
      end
      m_rel++;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_drop;
`ifdef CONTROL_FILTRO_DROPCNT_EN
    exp_drop = m_drop;
`else
    exp_drop = 8'd0;
`endif
    chk("in_ready",  W'(in_ready),  W'(!m_busy));
    chk("Enable",    W'(Enable),    W'(m_busy && m_rel == int'(SETTLE)));
    chk("busy",      W'(busy),      W'(m_busy));
    chk("out_valid", W'(out_valid), W'(m_ov));
    chk("out_data",  out_data,      m_out);
    chk("u",         u,             m_u);
    chk("drop_cnt",  W'(drop_cnt),  W'(exp_drop));
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic clr);
    in_valid = iv; in_data = d; out_ready = ordy; drop_clr = clr;
  endtask

  task automatic cycle();
    check_all();
    model_edge();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b1, 1'b0);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  logic [W-1:0] held;
  logic [7:0]   exp_bp;

  initial begin
    Reset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    model_reset();
    @(posedge CLK); #1;
    check_all();
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_u", u, '0);
    Reset = 1'b0;

    // Single 1.0 sample: Enable only in cycle E4..E5, out_valid after E5
    drive(1'b1, 25'h0008000, 1'b1, 1'b0); cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (SETTLE) cycle();
    chk("enable_at_capture", W'(Enable), W'(1));
    cycle();
    chk("out_valid_rise", W'(out_valid), W'(1));
    repeat (3) cycle();
    chk("enable_count_single", W'(en_seen), W'(m_en));

    // Impulse 1.0, 0, 0 through a freshly cleared filter
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, (k == 0) ? 25'h0008000 : 25'h0, 1'b1, 1'b0); cycle();
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (SETTLE + 1) cycle();
      chk($sformatf("impulse%0d", k), out_data,
          (k == 0) ? 25'h0004000 : (k == 1) ? 25'h1FFC000 : 25'h0);
      cycle();
    end
    chk("impulse_enables", W'(en_seen), W'(m_en));

    // Backpressure: 10 drops while stalled in OUT
    drive(1'b0, '0, 1'b1, 1'b1); cycle();
    drive(1'b1, 25'h0123456, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (SETTLE + 1) cycle();
    held = out_data;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, W'($urandom), 1'b0, 1'b0); cycle();
    end
`ifdef CONTROL_FILTRO_DROPCNT_EN
    exp_bp = 8'd10;
`else
    exp_bp = 8'd0;
`endif
    chk("bp_drop_cnt", W'(drop_cnt), W'(exp_bp));
    chk("bp_out_stable", out_data, held);
    chk("bp_no_enable", W'(en_seen), W'(m_en));
    drive(1'b0, '0, 1'b1, 1'b0); cycle();
    chk("bp_release_idle", W'(in_ready), W'(1));

    // Saturation, then clear colliding with a drop
    drive(1'b1, W'($urandom), 1'b0, 1'b0); cycle();
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, W'($urandom), 1'b0, 1'b0); cycle();
    end
`ifdef CONTROL_FILTRO_DROPCNT_EN
    chk("sat_255", W'(drop_cnt), W'(8'd255));
`endif
    drive(1'b1, W'($urandom), 1'b0, 1'b1); cycle();
    chk("clr_wins", W'(drop_cnt), '0);
    drive(1'b0, '0, 1'b1, 1'b0); cycle();

    // Reset asserted mid-SETTLE
    drive(1'b1, 25'h00ABCDE, 1'b1, 1'b0); cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) cycle();
    #2;
    do_reset();
    chk("midreset_u", u, '0);
    repeat (SETTLE + 3) cycle();
    chk("midreset_no_enable", W'(en_seen), W'(m_en));
    drive(1'b1, 25'h0008000, 1'b1, 1'b0); cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (SETTLE) cycle();
    chk("fresh_enable", W'(Enable), W'(1));
    repeat (3) cycle();

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (SETTLE + 3) cycle();
    chk("final_enable_count", W'(en_seen), W'(m_en));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_filtro.md
# control_filtro

Sample-rate sequencer for the 25-bit biquad high-pass filter datapath. It accepts one input sample from the acquisition side and holds it on the filter input `u`. It waits a programmable settle interval for the combinational adders and multipliers, then captures `y` and pulses the filter's `Enable` exactly once so the delay registers advance. It presents the result downstream with a valid/ready handshake. It sits between the ADC front end and the output/DAC path, and is the only driver of the filter's `u` and `Enable`.

## Interface
- `W`, 25, sample width; Q9.15 signed two's complement, matching the filter.
- `SETTLE`, 4, settle cycles between loading `u` and capturing `y`; legal range 1..255.
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  source presents a sample; the source is non-stallable.
- `in_data`  in  W  signed input sample.
- `in_ready`  out  1  block can accept a sample this cycle.
- `u`  out  W  registered sample driven to the filter input.
- `Enable`  out  1  one-cycle strobe to the filter delay registers.
- `y`  in  W  combinational filter output.
- `out_valid`  out  1  `out_data` holds a new filtered sample.
- `out_data`  out  W  registered filtered sample.
- `out_ready`  in  1  sink accepts `out_data`.
- `busy`  out  1  high whenever the state is not IDLE.
- `drop_cnt`  out  8  saturating count of lost input samples (see Configuration).
- `drop_clr`  in  1  synchronous clear of `drop_cnt`.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`, latch `u<=in_data`, load the settle counter with SETTLE-1, go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to CAPTURE.
  - CAPTURE: `Enable`=1 for this single cycle. At the closing edge, `out_data<=y` and `out_valid<=1`, then go to OUT.
  - OUT: hold `out_data` and `out_valid`. On `out_ready`, clear `out_valid` and go to IDLE.
- `Enable` and `in_ready` are decoded from the registered state only, with no input-to-output combinational path.
- `u` is stable from the accept edge through the end of CAPTURE. `y` is therefore sampled before the filter registers advance, on the same edge that advances them.
- `u` holds its last value while in IDLE and OUT. It changes only when a sample is accepted.
- Drop rule: any cycle with `in_valid`=1 and `in_ready`=0 counts as one lost sample. The source does not hold data, so that sample is lost.
- `drop_cnt` saturates at 255. If `drop_clr` and a drop occur in the same cycle, the clear wins and the count becomes 0.
- The block performs no arithmetic on samples; widths pass through unchanged.
- Reset values: state IDLE, `u`=0, `out_data`=0, `out_valid`=0, `Enable`=0, `in_ready`=1 (decoded from IDLE), `busy`=0, `drop_cnt`=0.
- The same `Reset` must clear the filter.
- Reset asserted mid-operation returns the block to IDLE immediately. No `Enable` pulse is issued, and a pending `out_valid` is discarded.

## Timing
- Accept at edge E0. SETTLE occupies the cycles E0..E(SETTLE). CAPTURE is the cycle E(SETTLE)..E(SETTLE+1), with `Enable` high. `out_valid` rises after E(SETTLE+1).
- Latency from accept to `out_valid` is SETTLE+1 cycles.
- With `out_ready` held at 1, OUT lasts one cycle and `in_ready` returns after E(SETTLE+2).
- Minimum sample period is SETTLE+3 cycles; for SETTLE=4 this is 7 cycles.
- Exactly one `Enable` pulse is issued per accepted sample. Zero pulses are issued for dropped samples.
- Backpressure: `out_ready`=0 stalls in OUT indefinitely. `Enable` stays low and every incoming `in_valid` counts as a drop.

## Configuration
- `CONTROL_FILTRO_DROPCNT_EN` defined: the drop counter and `drop_clr` logic are compiled in, as described above.
- Not defined: `drop_cnt` is tied to 8'd0, `drop_clr` is ignored, and no counter flops are synthesised. FSM behaviour is otherwise identical.

## Test plan
- Reset check: after Reset, `u`=0, `out_valid`=0, `Enable`=0, `in_ready`=1. Pulse `in_valid` with `in_data`=25'h0008000 (1.0) at E0 → `Enable` high only in the cycle E4..E5, and `out_valid` rises after E5.
- Impulse through the real filter (SETTLE=4, `out_ready`=1): inputs 1.0, 0, 0 → outputs 25'h0004000 (0.5), then ≈−0.51 (±1 LSB), with exactly 3 `Enable` pulses.
- Backpressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 throughout → `out_data` stable, no `Enable`, `drop_cnt`=10 (with macro). Then set `out_ready`=1 → back to IDLE next cycle.
- Saturation and clear (macro defined): 300 drop cycles → `drop_cnt`=255. Assert `drop_clr` together with a drop → 0.
- Reset mid-SETTLE: assert Reset at E2 → `out_valid` never rises, no `Enable` pulse, `u`=0, and a fresh accept behaves as in the first scenario.
- Macro undefined: repeat the backpressure scenario → `drop_cnt` stays 0 and the outputs are otherwise identical.
